// File: rtl/alu_mdu.sv
// alu_mdu: single-cycle ALU plus iterative shift-add multiplier and restoring divider
// behind a valid/ready handshake with registered result and flags.
module alu_mdu #(
    parameter int WIDTH = 32,
    parameter int SHW = $clog2(WIDTH)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [3:0]       op_i,
    input  logic [WIDTH-1:0] src_a_i,
    input  logic [WIDTH-1:0] src_b_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] result_o,
    output logic             overflow_o,
    output logic             carry_o,
    output logic             negative_o,
    output logic             zero_o
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_OR    = 4'd3;
    localparam logic [3:0] OP_XOR   = 4'd4;
    localparam logic [3:0] OP_SLT   = 4'd5;
    localparam logic [3:0] OP_SLTU  = 4'd6;
    localparam logic [3:0] OP_SLL   = 4'd7;
    localparam logic [3:0] OP_SRL   = 4'd8;
    localparam logic [3:0] OP_SRA   = 4'd9;
    localparam logic [3:0] OP_MUL   = 4'd10;
    localparam logic [3:0] OP_MULHU = 4'd11;
    localparam logic [3:0] OP_DIVU  = 4'd12;
    localparam logic [3:0] OP_REMU  = 4'd13;

    state_e           state, state_nx;
    logic             accept, iter_i, mul_i, mul_q, last, load, div_ok;
    logic             alu_ovf, alu_cy;
    logic [3:0]       op_q;
    logic [SHW-1:0]   cnt, sh;
    logic [WIDTH-1:0] hi, lo, opd, hi_nx, lo_nx, alu_res, it_res, nres;
    logic [WIDTH:0]   sum, dif, msum, shifted;

    assign ready_o = (state == IDLE) || (state == DONE && ready_i);
    assign valid_o = state == DONE;
    assign accept  = valid_i && ready_o;
    assign iter_i  = (op_i >= OP_MUL) && (op_i <= OP_REMU);
    assign mul_i   = (op_i == OP_MUL) || (op_i == OP_MULHU);
    assign mul_q   = (op_q == OP_MUL) || (op_q == OP_MULHU);
    assign last    = cnt == SHW'(WIDTH - 1);
    assign load    = (accept && !iter_i) || (state == BUSY && last);

    assign sh  = src_b_i[SHW-1:0];
    assign sum = {1'b0, src_a_i} + {1'b0, src_b_i};
    assign dif = {1'b0, src_a_i} - {1'b0, src_b_i};

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        alu_cy  = 1'b0;
        case (op_i)
            OP_ADD: begin
                alu_res = sum[WIDTH-1:0];
                alu_cy  = sum[WIDTH];
                alu_ovf = (src_a_i[WIDTH-1] == src_b_i[WIDTH-1]) && (sum[WIDTH-1] != src_a_i[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = dif[WIDTH-1:0];
                alu_cy  = dif[WIDTH];
                alu_ovf = (src_a_i[WIDTH-1] != src_b_i[WIDTH-1]) && (dif[WIDTH-1] != src_a_i[WIDTH-1]);
            end
            OP_AND:  alu_res = src_a_i & src_b_i;
            OP_OR:   alu_res = src_a_i | src_b_i;
            OP_XOR:  alu_res = src_a_i ^ src_b_i;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(src_a_i) < $signed(src_b_i)};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, dif[WIDTH]};
            OP_SLL:  alu_res = src_a_i << sh;
            OP_SRL:  alu_res = src_a_i >> sh;
            OP_SRA:  alu_res = $signed(src_a_i) >>> sh;
            default: alu_res = '0;
        endcase
    end

    // hi:lo is the product (multiplier shifts out of lo) or remainder:quotient
    // (dividend shifts out of lo); a zero divisor naturally yields all-ones/dividend.
    assign msum    = {1'b0, hi} + (lo[0] ? {1'b0, opd} : '0);
    assign shifted = {hi, lo[WIDTH-1]};
    assign div_ok  = shifted >= {1'b0, opd};
    assign hi_nx   = mul_q ? msum[WIDTH:1] : div_ok ? shifted[WIDTH-1:0] - opd : shifted[WIDTH-1:0];
    assign lo_nx   = mul_q ? {msum[0], lo[WIDTH-1:1]} : {lo[WIDTH-2:0], div_ok};
    assign it_res  = (op_q == OP_MUL || op_q == OP_DIVU) ? lo_nx : hi_nx;
    assign nres    = accept ? alu_res : it_res;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = iter_i ? BUSY : DONE;
            BUSY:    if (last) state_nx = DONE;
            DONE:    state_nx = accept ? (iter_i ? BUSY : DONE) : ready_i ? IDLE : DONE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= IDLE;
            op_q       <= '0;
            cnt        <= '0;
            hi         <= '0;
            lo         <= '0;
            opd        <= '0;
            result_o   <= '0;
            overflow_o <= 1'b0;
            carry_o    <= 1'b0;
            negative_o <= 1'b0;
            zero_o     <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                op_q <= op_i;
                cnt  <= '0;
                hi   <= '0;
                lo   <= mul_i ? src_b_i : src_a_i;
                opd  <= mul_i ? src_a_i : src_b_i;
            end else if (state == BUSY) begin
                hi  <= hi_nx;
                lo  <= lo_nx;
                cnt <= cnt + SHW'(1);
            end
            if (load) begin
                result_o   <= nres;
                overflow_o <= accept && alu_ovf;
                carry_o    <= accept && alu_cy;
                negative_o <= nres[WIDTH-1];
                zero_o     <= nres == '0;
            end
        end
    end
endmodule

// File: tb/tb_alu_mdu.sv
// tb_alu_mdu: directed vector table plus handshake, backpressure and reset-abort sequences.
module tb_alu_mdu;
    localparam int W = 32;

    logic         clk_i = 1'b0, rst_ni = 1'b0, valid_i = 1'b0, ready_i = 1'b1;
    logic [3:0]   op_i = '0;
    logic [W-1:0] src_a_i = '0, src_b_i = '0;
    logic         ready_o, valid_o, overflow_o, carry_o, negative_o, zero_o;
    logic [W-1:0] result_o;

    alu_mdu #(.WIDTH(W)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i), .ready_o(ready_o),
        .op_i(op_i), .src_a_i(src_a_i), .src_b_i(src_b_i), .valid_o(valid_o),
        .ready_i(ready_i), .result_o(result_o), .overflow_o(overflow_o),
        .carry_o(carry_o), .negative_o(negative_o), .zero_o(zero_o)
    );

    always #5 clk_i = ~clk_i;

    int total = 0, bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // flags packed as {overflow, carry, negative, zero}
    typedef struct {
        logic [3:0]  op;
        logic [31:0] a, b, res;
        logic [3:0]  fl;
        int          lat;
    } vec_t;

    vec_t v[28];

    task automatic do_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output int lat, output bit busy_bad);
        @(negedge clk_i);
        valid_i = 1'b1; op_i = op; src_a_i = a; src_b_i = b; ready_i = 1'b1;
        @(posedge clk_i);
        #1 valid_i = 1'b0;
        lat = 0;
        busy_bad = 1'b0;
        while (lat < 200) begin
            @(negedge clk_i);
            lat++;
            if (valid_o) break;
            if (ready_o) busy_bad = 1'b1;
        end
    endtask

    initial begin
        int lat;
        bit bb, stray;
        v[0]  = '{4'd0,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 4'b1010, 1};
        v[1]  = '{4'd0,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b0101, 1};
        v[2]  = '{4'd1,  32'h00000005, 32'h00000007, 32'hFFFFFFFE, 4'b0110, 1};
        v[3]  = '{4'd1,  32'h00000007, 32'h00000007, 32'h00000000, 4'b0001, 1};
        v[4]  = '{4'd1,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 4'b1000, 1};
        v[5]  = '{4'd2,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 4'b0010, 1};
        v[6]  = '{4'd3,  32'h0F0F0000, 32'h000000F0, 32'h0F0F00F0, 4'b0000, 1};
        v[7]  = '{4'd4,  32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F, 4'b0010, 1};
        v[8]  = '{4'd5,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 4'b0000, 1};
        v[9]  = '{4'd6,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b0001, 1};
        v[10] = '{4'd7,  32'h00000001, 32'h00000023, 32'h00000008, 4'b0000, 1};
        v[11] = '{4'd8,  32'h80000000, 32'h00000004, 32'h08000000, 4'b0000, 1};
        v[12] = '{4'd9,  32'h80000000, 32'h00000004, 32'hF8000000, 4'b0010, 1};
        v[13] = '{4'd9,  32'h40000000, 32'h0000003F, 32'h00000000, 4'b0001, 1};
        v[14] = '{4'd14, 32'h00000005, 32'h00000005, 32'h00000000, 4'b0001, 1};
        v[15] = '{4'd15, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 4'b0001, 1};
        v[16] = '{4'd10, 32'h00010000, 32'h00010000, 32'h00000000, 4'b0001, 33};
        v[17] = '{4'd11, 32'h00010000, 32'h00010000, 32'h00000001, 4'b0000, 33};
        v[18] = '{4'd10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 4'b0000, 33};
        v[19] = '{4'd11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 4'b0010, 33};
        v[20] = '{4'd10, 32'h12345678, 32'h00000010, 32'h23456780, 4'b0000, 33};
        v[21] = '{4'd12, 32'h00000007, 32'h00000000, 32'hFFFFFFFF, 4'b0010, 33};
        v[22] = '{4'd13, 32'h00000007, 32'h00000000, 32'h00000007, 4'b0000, 33};
        v[23] = '{4'd12, 32'd100,      32'd7,        32'd14,       4'b0000, 33};
        v[24] = '{4'd13, 32'd100,      32'd7,        32'd2,        4'b0000, 33};
        v[25] = '{4'd12, 32'd3,        32'd5,        32'd0,        4'b0001, 33};
        v[26] = '{4'd13, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 4'b0000, 33};
        v[27] = '{4'd12, 32'hFFFFFFFF, 32'h00000010, 32'h0FFFFFFF, 4'b0000, 33};

        #12;
        chk("rst_valid", valid_o, 0);
        chk("rst_ready", ready_o, 1);
        chk("rst_result", result_o, 0);
        chk("rst_flags", {overflow_o, carry_o, negative_o, zero_o}, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        for (int i = 0; i < 28; i++) begin
            do_op(v[i].op, v[i].a, v[i].b, lat, bb);
            chk($sformatf("v%0d_lat", i), lat, v[i].lat);
            chk($sformatf("v%0d_res", i), result_o, v[i].res);
            chk($sformatf("v%0d_flags", i), {overflow_o, carry_o, negative_o, zero_o}, v[i].fl);
            if (v[i].lat > 1) chk($sformatf("v%0d_busy_ready", i), bb, 0);
        end

        // back-to-back single-cycle ops: one result per cycle
        @(negedge clk_i);
        valid_i = 1'b1; op_i = 4'd0; src_a_i = 1; src_b_i = 1; ready_i = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk_i);
            chk($sformatf("b2b%0d_valid", k), valid_o, 1);
            chk($sformatf("b2b%0d_res", k), result_o, 2 * k);
            chk($sformatf("b2b%0d_ready", k), ready_o, 1);
            src_a_i = k + 1;
            src_b_i = k + 1;
            if (k == 3) valid_i = 1'b0;
        end

        // backpressure: hold 0xFFFFFFFF+2 for 5 cycles while inputs churn
        @(negedge clk_i);
        valid_i = 1'b1; op_i = 4'd0; src_a_i = 32'hFFFFFFFF; src_b_i = 2; ready_i = 1'b0;
        @(posedge clk_i);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            chk($sformatf("hold%0d_valid", i), valid_o, 1);
            chk($sformatf("hold%0d_res", i), result_o, 1);
            chk($sformatf("hold%0d_flags", i), {overflow_o, carry_o, negative_o, zero_o}, 4'b0100);
            chk($sformatf("hold%0d_ready", i), ready_o, 0);
            valid_i = (i % 2) == 0;
            op_i = 4'(i + 1);
            src_a_i = $urandom;
            src_b_i = $urandom;
        end
        @(negedge clk_i);
        ready_i = 1'b1; valid_i = 1'b1; op_i = 4'd1; src_a_i = 9; src_b_i = 4;
        #1 chk("bp_release_ready", ready_o, 1);
        @(posedge clk_i);
        #1 valid_i = 1'b0;
        @(negedge clk_i);
        chk("bp_next_valid", valid_o, 1);
        chk("bp_next_res", result_o, 5);
        chk("bp_next_flags", {overflow_o, carry_o, negative_o, zero_o}, 4'b0000);

        // reset mid-division aborts it
        @(negedge clk_i);
        valid_i = 1'b1; op_i = 4'd12; src_a_i = 100; src_b_i = 7;
        @(posedge clk_i);
        #1 valid_i = 1'b0;
        repeat (10) @(negedge clk_i);
        chk("mid_busy_valid", valid_o, 0);
        rst_ni = 1'b0;
        #1;
        chk("abort_valid", valid_o, 0);
        chk("abort_result", result_o, 0);
        chk("abort_flags", {overflow_o, carry_o, negative_o, zero_o}, 0);
        chk("abort_ready", ready_o, 1);
        @(negedge clk_i);
        rst_ni = 1'b1;
        stray = 1'b0;
        repeat (40) begin
            @(negedge clk_i);
            if (valid_o) stray = 1'b1;
        end
        chk("abort_no_result", stray, 0);
        chk("abort_idle_ready", ready_o, 1);
        do_op(4'd0, 2, 3, lat, bb);
        chk("post_abort_lat", lat, 1);
        chk("post_abort_res", result_o, 5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alu_mdu.md
ALU_MDU -- requirements
Module: alu_mdu

Interface
REQ-001 Parameter WIDTH, default 32, datapath width in bits; legal range 8..64, power of two.
REQ-002 Parameter SHW, default $clog2(WIDTH), shift-amount width; derived, not overridden.
REQ-003 clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 rst_ni  input  1  reset, asynchronous assert, active-low.
REQ-005 valid_i  input  1  operation request valid.
REQ-006 ready_o  output  1  block can accept a request this cycle.
REQ-007 op_i  input  4  operation code (REQ-012).
REQ-008 src_a_i, src_b_i  input  WIDTH  operands.
REQ-009 valid_o  output  1  result and flags valid.
REQ-010 ready_i  input  1  consumer accepts result.
REQ-011 result_o  output  WIDTH; overflow_o, carry_o, negative_o, zero_o  output  1 each  registered result and flags.

Function
REQ-012 op_i encoding: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLTU, 7 SLL, 8 SRL, 9 SRA, 10 MUL (low WIDTH bits), 11 MULHU (high WIDTH bits, unsigned), 12 DIVU, 13 REMU, 14-15 reserved.
REQ-013 FSM states IDLE, BUSY, DONE; reset state IDLE.
REQ-014 Accept = valid_i && ready_o; ready_o = (state==IDLE) || (state==DONE && ready_i); operands and op captured on accept only.
REQ-015 Ops 0-9 and 14-15 single-cycle: accept in cycle N -> DONE, valid_o=1 in cycle N+1.
REQ-016 Ops 10-13 iterative, one bit per cycle: accept in N -> BUSY for WIDTH cycles -> valid_o=1 in cycle N+WIDTH+1.
REQ-017 MUL/MULHU: unsigned shift-add over 2*WIDTH-bit product; MUL returns bits [WIDTH-1:0], MULHU bits [2*WIDTH-1:WIDTH].
REQ-018 DIVU/REMU: unsigned restoring division; divisor 0 -> quotient all ones, remainder = src_a_i, same latency as nonzero divisor.
REQ-019 Shifts use src_b_i[SHW-1:0] only; SRA replicates src_a_i[WIDTH-1].
REQ-020 SLT signed compare, SLTU unsigned compare; result 1 or 0 zero-extended to WIDTH.
REQ-021 overflow_o = signed overflow for ADD/SUB only; 0 for all other ops.
REQ-022 carry_o = carry-out for ADD, borrow (src_a_i < src_b_i unsigned) for SUB; 0 for all other ops.
REQ-023 negative_o = result_o[WIDTH-1]; zero_o = (result_o==0); valid for every op including reserved.
REQ-024 Reserved ops: result_o=0, overflow_o=carry_o=0, zero_o=1, single-cycle latency.
REQ-025 In DONE with ready_i=0: valid_o stays 1, result_o and all flags held stable, ready_o=0, valid_i ignored.
REQ-026 In DONE with ready_i=1 and accept: new op starts same cycle (back-to-back); single-cycle ops sustain one result per cycle.
REQ-027 In DONE with ready_i=1 and no accept: next state IDLE, valid_o=0.
REQ-028 In BUSY: ready_o=0, valid_o=0, valid_i and op_i changes ignored, result_o holds previous value.

Reset
REQ-029 rst_ni=0 asynchronously forces state IDLE, valid_o=0, result_o=0, all flags 0, iteration counter and internal product/quotient registers 0; ready_o=1 while in reset.
REQ-030 Reset during BUSY or DONE aborts the operation; no result is ever presented for it after release.
REQ-031 First accept possible on first rising edge with rst_ni=1.

Verification
REQ-032 WIDTH=32, ADD 0x7FFFFFFF+0x00000001 -> cycle N+1: result 0x80000000, overflow 1, carry 0, negative 1, zero 0.
REQ-033 SUB 5-7 -> result 0xFFFFFFFE, carry 1, overflow 0, negative 1; SUB 7-7 -> result 0, zero 1, carry 0.
REQ-034 MUL 0x00010000*0x00010000 -> result 0, zero 1; MULHU same operands -> 0x00000001; valid_o rises exactly 33 cycles after accept, ready_o 0 throughout BUSY.
REQ-035 DIVU 7/0 -> 0xFFFFFFFF; REMU 7/0 -> 0x00000007; DIVU 100/7 -> 14; REMU 100/7 -> 2; all at 33-cycle latency.
REQ-036 Backpressure: ADD result held with ready_i=0 for 5 cycles while valid_i toggles -> result/flags unchanged, ready_o 0; ready_i=1 with valid_i=1 -> next op accepted same cycle, its result next cycle.
REQ-037 rst_ni pulsed low mid-DIVU (cycle 10 of 32) -> outputs zero immediately, valid_o stays 0 after release, ready_o 1, subsequent ADD 2+3 -> 5 at 1-cycle latency.
